whack_guard: RTL and testbench

Input-qualification block for the whack-a-mole game. It sits between the player buttons / mole randomiser and the score counter. It turns raw button presses into at most one hit pulse per mole appearance, and flags cheating: pressing with no mole lit, or pressing a wrong lane while a mole is lit. Its outputs drive the score counter's increment and clear inputs.

---
 rtl/whack_guard_if.sv | 27 ++
 rtl/whack_guard.sv | 95 +++++++++
 tb/tb_whack_guard.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/whack_guard_if.sv
`default_nettype none
// ============================================================================
// whack_guard_if : button/mole inputs and qualified hit/cheat outputs
// Revision 1.0
// ============================================================================
interface whack_guard_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0] btn;
    logic [LANES-1:0] mole;
    logic             hit;
    logic             cheat;
    logic             cheat_nomole;
    logic             cheat_multi;
    logic             armed;

    modport master (
        output btn, mole,
        input  hit, cheat, cheat_nomole, cheat_multi, armed
    );

    modport slave (
        input  btn, mole,
        output hit, cheat, cheat_nomole, cheat_multi, armed
    );
endinterface
`default_nettype wire

// File: rtl/whack_guard.sv
`default_nettype none
// ============================================================================
// whack_guard : qualifies button presses into one hit per mole window, flags cheats
// Revision 1.0
// ============================================================================
module whack_guard #(
    parameter int LANES = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    whack_guard_if.slave bus
);
    localparam int CNT_W = $clog2(LANES + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LANES-1:0] btn_meta_q, btn_s_q;
    logic [LANES-1:0] mole_p_q, mole_d_q, prev_mole_q;
    logic             hit_q, cheat_q, nomole_q, multi_q;

    logic [LANES-1:0] act_c;
    logic [CNT_W-1:0] act_cnt_c;
    logic             nomole_c, multi_c, match_c, cheat_c, new_mole_c, hit_d;

    // Mole is delayed two cycles so it lines up with the synchronized buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= '0;
            btn_s_q     <= '0;
            mole_p_q    <= '0;
            mole_d_q    <= '0;
            prev_mole_q <= '0;
        end else begin
            btn_meta_q  <= bus.btn;
            btn_s_q     <= btn_meta_q;
            mole_p_q    <= bus.mole;
            mole_d_q    <= mole_p_q;
            prev_mole_q <= mole_d_q;
        end
    end

    always_comb begin
        act_c     = btn_s_q | mole_d_q;
        act_cnt_c = '0;
        for (int i = 0; i < LANES; i++) begin
            act_cnt_c = act_cnt_c + CNT_W'(act_c[i]);
        end
    end

    assign nomole_c   = (|btn_s_q) & ~(|mole_d_q);
    assign multi_c    = (act_cnt_c >= CNT_W'(2));
    assign match_c    = |(btn_s_q & mole_d_q);
    assign cheat_c    = nomole_c | multi_c;
    // A jump straight to another lane opens a fresh window too
    assign new_mole_c = (|mole_d_q) & (mole_d_q != prev_mole_q);
    assign hit_d      = match_c & (state_q == ST_ARMED) & ~cheat_c & ~new_mole_c;

    always_comb begin
        state_d = state_q;
        if (new_mole_c) begin
            state_d = ST_ARMED;
        end else if (hit_d) begin
            state_d = ST_IDLE;
        end else if (mole_d_q == '0) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hit_q    <= 1'b0;
            cheat_q  <= 1'b0;
            nomole_q <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            cheat_q  <= cheat_c;
            nomole_q <= nomole_c;
            multi_q  <= multi_c;
        end
    end

    assign bus.hit          = hit_q;
    assign bus.cheat        = cheat_q;
    assign bus.cheat_nomole = nomole_q;
    assign bus.cheat_multi  = multi_q;
    assign bus.armed        = (state_q == ST_ARMED);
endmodule
`default_nettype wire

// File: tb/tb_whack_guard.sv
`default_nettype none
// ============================================================================
// tb_whack_guard : scoreboard bench; expected outputs queued with their due cycle
// Revision 1.0
// ============================================================================
module tb_whack_guard;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    int   hit_cnt;

    typedef struct {
        int         due;
        logic [4:0] exp;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [4:0] obs;

    whack_guard_if #(.LANES(4)) bus ();

    whack_guard #(.LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // {hit, cheat, cheat_nomole, cheat_multi, armed}
    assign obs = {bus.hit, bus.cheat, bus.cheat_nomole, bus.cheat_multi, bus.armed};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.hit === 1'b1) hit_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        int b;
        rst_n    = 1'b0;
        bus.btn  = 4'b1111;
        bus.mole = 4'b0010;
        repeat (3) step();
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_hold got=%b expected=%b", obs, 5'b00000);
        end
        rst_n = 1'b1;
        b = cyc;
        sb.push_back('{b + 2, 5'b00000});
        sb.push_back('{b + 3, 5'b01011});
        sb.push_back('{b + 5, 5'b01011});
        sb.push_back('{b + 6, 5'b00001});
        for (int k = 1; k <= 7; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL reset cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
            if (k == 3) bus.btn = 4'b0000;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL reset_pending got=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_clean_hit();
        int b;
        hit_cnt  = 0;
        b        = cyc;
        bus.mole = 4'b0100;
        bus.btn  = 4'b0000;
        sb.push_back('{b + 4,  5'b00001});
        sb.push_back('{b + 6,  5'b00001});
        sb.push_back('{b + 7,  5'b10000});
        sb.push_back('{b + 8,  5'b00000});
        sb.push_back('{b + 14, 5'b00000});
        for (int k = 1; k <= 15; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL clean_hit cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
            if (k == 4)  bus.btn = 4'b0100;
            if (k == 14) bus.btn = 4'b0000;
        end
        checks++;
        if (hit_cnt != 1) begin
            failures++;
            $display("FAIL clean_hit_count got=%0d expected=1", hit_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL clean_hit_pending got=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_repeat_clicks();
        int b;
        hit_cnt = 0;
        b       = cyc;
        sb.push_back('{b + 5,  5'b00000});
        sb.push_back('{b + 8,  5'b00000});
        sb.push_back('{b + 12, 5'b00000});
        sb.push_back('{b + 17, 5'b00001});
        sb.push_back('{b + 20, 5'b00001});
        sb.push_back('{b + 21, 5'b10000});
        sb.push_back('{b + 22, 5'b00000});
        for (int k = 1; k <= 24; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL repeat_clicks cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
            if (k <= 10) bus.btn = (k % 2 == 1) ? 4'b0100 : 4'b0000;
            if (k == 14) bus.mole = 4'b0001;
            if (k == 18) bus.btn  = 4'b0001;
        end
        checks++;
        if (hit_cnt != 1) begin
            failures++;
            $display("FAIL repeat_clicks_count got=%0d expected=1", hit_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL repeat_clicks_pending got=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_nomole();
        int b;
        hit_cnt  = 0;
        b        = cyc;
        bus.mole = 4'b0000;
        bus.btn  = 4'b0000;
        sb.push_back('{b + 3,  5'b00000});
        sb.push_back('{b + 6,  5'b00000});
        sb.push_back('{b + 7,  5'b01100});
        sb.push_back('{b + 9,  5'b01100});
        sb.push_back('{b + 11, 5'b01100});
        sb.push_back('{b + 12, 5'b00000});
        for (int k = 1; k <= 13; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL nomole cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
            if (k == 4) bus.btn = 4'b0010;
            if (k == 9) bus.btn = 4'b0000;
        end
        checks++;
        if (hit_cnt != 0) begin
            failures++;
            $display("FAIL nomole_count got=%0d expected=0", hit_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL nomole_pending got=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_wrong_lane();
        int b;
        hit_cnt  = 0;
        b        = cyc;
        bus.mole = 4'b1000;
        bus.btn  = 4'b0000;
        sb.push_back('{b + 3,  5'b00001});
        sb.push_back('{b + 6,  5'b00001});
        sb.push_back('{b + 7,  5'b01011});
        sb.push_back('{b + 10, 5'b01011});
        sb.push_back('{b + 11, 5'b01011});
        sb.push_back('{b + 14, 5'b01011});
        sb.push_back('{b + 15, 5'b00001});
        for (int k = 1; k <= 16; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL wrong_lane cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
            if (k == 4)  bus.btn = 4'b0001;
            if (k == 8)  bus.btn = 4'b1001;
            if (k == 12) bus.btn = 4'b0000;
        end
        checks++;
        if (hit_cnt != 0) begin
            failures++;
            $display("FAIL wrong_lane_count got=%0d expected=0", hit_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL wrong_lane_pending got=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_async_reset();
        int b;
        b        = cyc;
        bus.mole = 4'b0100;
        bus.btn  = 4'b0000;
        sb.push_back('{b + 3, 5'b00001});
        for (int k = 1; k <= 4; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL async_pre cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL async_clear got=%b expected=%b", obs, 5'b00000);
        end
        #1 rst_n = 1'b1;
        hit_cnt = 0;
        b       = cyc;
        sb.push_back('{b + 2, 5'b00000});
        sb.push_back('{b + 3, 5'b00001});
        sb.push_back('{b + 6, 5'b00001});
        sb.push_back('{b + 7, 5'b10000});
        sb.push_back('{b + 8, 5'b00000});
        for (int k = 1; k <= 9; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL async_post cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
            if (k == 4) bus.btn = 4'b0100;
        end
        checks++;
        if (hit_cnt != 1) begin
            failures++;
            $display("FAIL async_count got=%0d expected=1", hit_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL async_pending got=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    // Mole and matching button arrive together: first cycle only arms
    task automatic test_back_to_back();
        int b;
        hit_cnt  = 0;
        b        = cyc;
        bus.mole = 4'b0000;
        bus.btn  = 4'b0000;
        sb.push_back('{b + 3, 5'b00000});
        sb.push_back('{b + 6, 5'b00000});
        sb.push_back('{b + 7, 5'b00001});
        sb.push_back('{b + 8, 5'b10000});
        sb.push_back('{b + 9, 5'b00000});
        for (int k = 1; k <= 10; k++) begin
            step();
            while (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.exp) begin
                    failures++;
                    $display("FAIL back_to_back cyc=%0d got=%b expected=%b", cyc - b, obs, e.exp);
                end
            end
            if (k == 4) begin
                bus.mole = 4'b0010;
                bus.btn  = 4'b0010;
            end
        end
        checks++;
        if (hit_cnt != 1) begin
            failures++;
            $display("FAIL back_to_back_count got=%0d expected=1", hit_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL back_to_back_pending got=%0d expected=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        hit_cnt  = 0;
        rst_n    = 1'b0;
        bus.btn  = '0;
        bus.mole = '0;
        test_reset();
        test_clean_hit();
        test_repeat_clicks();
        test_nomole();
        test_wrong_lane();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
